// File: rtl/i_fetch_pkg.sv
// i_fetch_pkg
// Shared definitions for the instruction-fetch refill path.
// Contents:
//   refill_state_t - refill sequencer states (IDLE, REQ, RECV, DRAIN, FILL)
//   BLOCK_WORDS    - instructions per cache block (4)
//   WORD_IDX_W     - width of the word index within a block (2)
//   MAX_ADDR_W     - widest address block_align accepts
//   block_align()  - clears the word-index bits of a word address
package i_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RECV,
    DRAIN,
    FILL
  } refill_state_t;

  localparam int BLOCK_WORDS = 4;
  localparam int WORD_IDX_W  = 2;
  localparam int MAX_ADDR_W  = 64;

  // Callers zero-extend into MAX_ADDR_W and truncate the result back to their own width.
  function automatic logic [MAX_ADDR_W-1:0] block_align(input logic [MAX_ADDR_W-1:0] address);
    return {address[MAX_ADDR_W-1:WORD_IDX_W], {WORD_IDX_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_refill_controller_refill_buffer.sv
// refill_buffer
// Assembly register for one instruction block. Each write stores one word
// into the slot chosen by index; the whole block is presented packed.
// Ports:
//   clk, reset    - clock, synchronous active-high reset (clears the block)
//   write_enable  - store write_data this cycle
//   index         - destination word slot (0..BLOCK_WORDS-1)
//   write_data    - word to store
//   block         - packed block, word i at [i*DATA_WIDTH +: DATA_WIDTH]
module refill_buffer
  import i_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              write_enable,
  input  logic [WORD_IDX_W-1:0]             index,
  input  logic [DATA_WIDTH-1:0]             write_data,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] block
);

  always_ff @(posedge clk) begin
    if (reset) begin
      block <= '0;
    end else if (write_enable) begin
      block[int'(index)*DATA_WIDTH +: DATA_WIDTH] <= write_data;
    end
  end

endmodule

// File: rtl/icache_refill_controller.sv
// icache_refill_controller
// Block-refill sequencer for the instruction fetch path. A cache miss issues
// one block read to memory, the four returned words are assembled and handed
// to the fetch queue as a single packed block. A flush (abort) cancels the
// refill; words already requested from memory are drained and discarded.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   miss_valid          - miss request, only accepted while idle
//   miss_address        - word address of the missing instruction
//   abort               - jump/branch flush
//   mem_req, mem_addr   - block read request and its block-aligned address
//   mem_ready           - memory accepts the request this cycle
//   mem_rvalid          - one returned word this cycle
//   mem_rdata           - returned word, in order 0..3
//   fill_valid          - one-cycle pulse qualifying fill_address/fill_block
//   fill_address        - block-aligned address of fill_block
//   fill_block          - assembled block, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy                - refill in progress
module icache_refill_controller
  import i_fetch_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              miss_valid,
  input  logic [ADDRESS_WIDTH-1:0]          miss_address,
  input  logic                              abort,
  output logic                              mem_req,
  output logic [ADDRESS_WIDTH-1:0]          mem_addr,
  input  logic                              mem_ready,
  input  logic                              mem_rvalid,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              fill_valid,
  output logic [ADDRESS_WIDTH-1:0]          fill_address,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] fill_block,
  output logic                              busy
);

  localparam int OUT_W = WORD_IDX_W + 1;
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(BLOCK_WORDS - 1);

  refill_state_t           state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [WORD_IDX_W-1:0]   count_q, count_d;
  logic [OUT_W-1:0]        outstanding_q, outstanding_d;
  logic                    buffer_write;

  refill_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buffer (
    .clk          (clk),
    .reset        (reset),
    .write_enable (buffer_write),
    .index        (count_q),
    .write_data   (mem_rdata),
    .block        (fill_block)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    buffer_write  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_valid && !abort) begin
          base_d  = ADDRESS_WIDTH'(block_align(MAX_ADDR_W'(miss_address)));
          state_d = REQ;
        end
      end

      REQ: begin
        if (mem_ready) begin
          count_d = '0;
          if (abort) begin
            // Memory has already accepted the read, so the whole block will still arrive.
            state_d       = DRAIN;
            outstanding_d = OUT_W'(BLOCK_WORDS);
          end else begin
            state_d = RECV;
          end
        end else if (abort) begin
          state_d = IDLE;
        end
      end

      RECV: begin
        if (mem_rvalid) begin
          buffer_write = 1'b1;
          count_d      = count_q + 1'b1;
        end
        if (abort) begin
          // A word arriving in the abort cycle counts as received; if it was
          // the last one there is nothing left to drain.
          if (mem_rvalid && count_q == LAST_WORD) begin
            state_d = IDLE;
          end else begin
            state_d       = DRAIN;
            outstanding_d = OUT_W'(BLOCK_WORDS) - {1'b0, count_q}
                            - {{WORD_IDX_W{1'b0}}, mem_rvalid};
          end
        end else if (mem_rvalid && count_q == LAST_WORD) begin
          state_d = FILL;
        end
      end

      DRAIN: begin
        if (mem_rvalid) begin
          outstanding_d = outstanding_q - 1'b1;
          if (outstanding_q == OUT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end

      FILL: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // fill_valid is the one output gated by an input: a flush in the FILL cycle
  // must keep a stale block out of the fetch queue.
  always_comb begin
    mem_req      = (state_q == REQ);
    mem_addr     = base_q;
    fill_address = base_q;
    fill_valid   = (state_q == FILL) && !abort;
    busy         = (state_q != IDLE);
  end

endmodule

// File: tb/tb_icache_refill_controller.sv
// tb_icache_refill_controller
// Self-checking bench for icache_refill_controller. Each refill scenario is
// planned as a timeline (request cycles, word arrival cycles, abort cycle),
// the expected busy/mem_req/fill_valid windows are derived from that timeline,
// and the DUT outputs are compared cycle by cycle.
module tb_icache_refill_controller;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXC = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic           miss_valid;
  logic [AW-1:0]  miss_address;
  logic           abort;
  logic           mem_req;
  logic [AW-1:0]  mem_addr;
  logic           mem_ready;
  logic           mem_rvalid;
  logic [DW-1:0]  mem_rdata;
  logic           fill_valid;
  logic [AW-1:0]  fill_address;
  logic [4*DW-1:0] fill_block;
  logic           busy;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  icache_refill_controller #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .miss_valid   (miss_valid),
    .miss_address (miss_address),
    .abort        (abort),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .fill_valid   (fill_valid),
    .fill_address (fill_address),
    .fill_block   (fill_block),
    .busy         (busy)
  );

  task automatic checkOutput(input string tag, input logic [4*DW-1:0] actual,
                             input logic [4*DW-1:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // mode: 0 normal, 1 abort in REQ before accept, 2 abort at accept,
  //       3 abort during RECV, 4 abort during FILL, 5 miss+abort together in IDLE
  task automatic applyStimulus(input logic [AW-1:0] addr, input int rdy_wait,
                               input int mode, input int unsigned abort_sel,
                               input int gap_lo, input int gap_hi,
                               input bit hold_miss, input logic [DW-1:0] word_base,
                               input int trailing);
    logic          mv[MAXC];
    logic          ab[MAXC];
    logic          rdy[MAXC];
    logic          rv[MAXC];
    logic [DW-1:0] rd[MAXC];
    logic          eReq[MAXC];
    logic          eBusy[MAXC];
    logic          eFill[MAXC];
    logic [DW-1:0] words[4];
    logic [AW-1:0] aligned;
    int            wc[4];
    int            acc, endIdle, abortC, c, n;

    aligned = addr & ~32'h3;
    for (int i = 0; i < MAXC; i++) begin
      mv[i] = 0; ab[i] = 0; rdy[i] = 0; rv[i] = 0; rd[i] = '0;
      eReq[i] = 0; eBusy[i] = 0; eFill[i] = 0;
    end
    for (int w = 0; w < 4; w++) begin
      words[w] = (word_base != 0) ? word_base + DW'(w) : DW'($urandom);
      wc[w] = 0;
    end

    mv[0] = 1;
    if (mode == 5) begin
      ab[0]   = 1;
      endIdle = 1;
    end else begin
      if (mode == 1 && rdy_wait == 0) rdy_wait = 1;
      acc = 1 + rdy_wait;
      for (c = 1; c <= acc; c++) begin
        eReq[c]  = 1;
        eBusy[c] = 1;
      end
      rdy[acc] = 1;
      if (mode == 1) begin
        abortC   = 1 + int'(abort_sel % rdy_wait);
        rdy[acc] = 0;
        for (c = abortC + 1; c <= acc; c++) begin
          eReq[c]  = 0;
          eBusy[c] = 0;
        end
        ab[abortC] = 1;
        endIdle    = abortC + 1;
      end else begin
        c = acc + 1;
        for (int w = 0; w < 4; w++) begin
          if (w > 0) c += int'($urandom_range(gap_hi, gap_lo));
          wc[w] = c;
          rv[c] = 1;
          rd[c] = words[w];
          c++;
        end
        for (c = acc + 1; c <= wc[3]; c++) eBusy[c] = 1;
        if (mode == 0 || mode == 4) begin
          eBusy[wc[3] + 1] = 1;
          eFill[wc[3] + 1] = (mode == 0);
          ab[wc[3] + 1]    = (mode == 4);
          endIdle          = wc[3] + 2;
        end else begin
          abortC = (mode == 2) ? acc : acc + 1 + int'(abort_sel % (wc[3] - acc));
          ab[abortC] = 1;
          for (c = abortC + 1; c <= wc[3]; c++) ab[c] = 1'($urandom_range(1, 0));
          endIdle = wc[3] + 1;
        end
      end
    end
    if (hold_miss) begin
      for (c = 1; c < endIdle; c++) mv[c] = 1;
    end
    n = endIdle + 1 + trailing;

    for (c = 0; c < n; c++) begin
      @(negedge clk);
      miss_valid   = mv[c];
      miss_address = (c == 0) ? addr : AW'($urandom);
      abort        = ab[c];
      mem_ready    = rdy[c];
      mem_rvalid   = rv[c];
      mem_rdata    = rv[c] ? rd[c] : DW'($urandom);
      #1;
      checkOutput("busy", busy, eBusy[c]);
      checkOutput("mem_req", mem_req, eReq[c]);
      if (eReq[c]) checkOutput("mem_addr", mem_addr, aligned);
      checkOutput("fill_valid", fill_valid, eFill[c]);
      if (eFill[c]) begin
        checkOutput("fill_address", fill_address, aligned);
        checkOutput("fill_block", fill_block, {words[3], words[2], words[1], words[0]});
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_req"}, mem_req, '0);
    checkOutput({tag, "_mem_addr"}, mem_addr, '0);
    checkOutput({tag, "_fill_valid"}, fill_valid, '0);
    checkOutput({tag, "_fill_address"}, fill_address, '0);
    checkOutput({tag, "_fill_block"}, fill_block, '0);
    checkOutput({tag, "_busy"}, busy, '0);
  endtask

  // Reset while one word of a block has been received; memory is reset alongside.
  task automatic applyMidReset(input logic [AW-1:0] addr);
    @(negedge clk);
    miss_valid = 1; miss_address = addr; abort = 0; mem_ready = 0; mem_rvalid = 0;
    @(negedge clk);
    miss_valid = 0; mem_ready = 1;
    #1 checkOutput("rst_pre_req", mem_req, 1'b1);
    @(negedge clk);
    mem_ready = 0; mem_rvalid = 1; mem_rdata = DW'($urandom);
    @(negedge clk);
    mem_rvalid = 0; reset = 1;
    #1 checkOutput("rst_pre_busy", busy, 1'b1);
    @(negedge clk);
    reset = 0;
    #1 checkAllZero("rst_mid");
  endtask

  initial begin
    reset = 1; miss_valid = 0; miss_address = '0; abort = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1 checkAllZero("reset");
    @(negedge clk);
    reset = 0;

    $display("[TB] basic refill");
    applyStimulus(32'h103, 0, 0, 0, 0, 0, 0, 32'hA0, 0);
    $display("[TB] backpressure and gaps");
    applyStimulus(AW'($urandom), 3, 0, 0, 1, 1, 0, 0, 1);
    $display("[TB] abort before accept, then refill at 0x200");
    applyStimulus(AW'($urandom), 3, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(32'h200, 0, 0, 0, 0, 0, 0, 0, 1);
    $display("[TB] abort mid-receive");
    applyStimulus(AW'($urandom), 0, 3, 3, 1, 1, 0, 0, 1);
    $display("[TB] collisions");
    applyStimulus(AW'($urandom), 0, 5, 0, 0, 0, 0, 0, 1);
    applyStimulus(AW'($urandom), 1, 4, 0, 0, 1, 0, 0, 1);
    applyStimulus(AW'($urandom), 0, 0, 0, 0, 2, 1, 0, 1);
    $display("[TB] abort at accept");
    applyStimulus(AW'($urandom), 2, 2, 0, 0, 2, 1, 0, 0);
    $display("[TB] reset mid-refill");
    applyMidReset(AW'($urandom));
    applyStimulus(AW'($urandom), 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] randomized refills");
    for (int k = 0; k < 80; k++) begin
      applyStimulus(AW'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(5, 0)),
                    $urandom, 0, 2, 1'($urandom_range(1, 0)), 0,
                    int'($urandom_range(2, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
